// File: rtl/fpga_reset_boot_sequencer.sv
// fpga_reset_boot_sequencer
// Reset and boot sequencer for the FPGA HEEPerator platform. Waits for the
// clock wizard to lock, holds the SoC in reset for RST_HOLD_CYCLES, latches
// the boot straps at release and captures the program exit code.
// Optional feature macro: RST_DEBOUNCE_EN (button debounce filter).
module fpga_reset_boot_sequencer #(
   parameter int unsigned RST_HOLD_CYCLES      = 32,
   parameter int unsigned DEBOUNCE_CYCLES      = 16,
   parameter int unsigned CLK_LED_COUNT_LENGTH = 27
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rst_btn_i,
   input  logic        pll_locked_i,
   input  logic        boot_select_i,
   input  logic        execute_from_flash_i,
   input  logic        exit_valid_i,
   input  logic [31:0] exit_value_i,
   output logic        soc_rst_no,
   output logic        boot_select_o,
   output logic        execute_from_flash_o,
   output logic        exit_done_o,
   output logic [31:0] exit_value_o,
   output logic [2:0]  state_o,
   output logic        rst_led_o,
   output logic        clk_led_o,
   output logic        exit_led_o
);

   localparam int unsigned HoldCntW = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [CLK_LED_COUNT_LENGTH-1:0] LedOne = 1;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      DONE      = 3'd4
   } state_e;

   // Reject parameter values that would make the sequencer meaningless.
   if (RST_HOLD_CYCLES < 1) begin : gen_bad_hold
      $error("RST_HOLD_CYCLES must be at least 1");
   end
   if (DEBOUNCE_CYCLES < 1) begin : gen_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end

   logic [1:0] btnSync_q;
   logic [1:0] lockSync_q;
   logic [1:0] bootSync_q;
   logic [1:0] flashSync_q;

   logic btnFilt;
   logic btnPrev_q;
   logic btnEvent;
   logic lockSync;

   state_e state_q, state_d;
   logic [HoldCntW-1:0] holdCnt_q, holdCnt_d;
   logic bootLatch_q, bootLatch_d;
   logic flashLatch_q, flashLatch_d;
   logic exitDone_q, exitDone_d;
   logic [31:0] exitValue_q, exitValue_d;
   logic socRstN_q, socRstN_d;
   logic [CLK_LED_COUNT_LENGTH-1:0] ledCnt_q;

   // Two-flop synchronisers for every asynchronous board-level input.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btnSync_q   <= '0;
         lockSync_q  <= '0;
         bootSync_q  <= '0;
         flashSync_q <= '0;
      end else begin
         btnSync_q   <= {btnSync_q[0], rst_btn_i};
         lockSync_q  <= {lockSync_q[0], pll_locked_i};
         bootSync_q  <= {bootSync_q[0], boot_select_i};
         flashSync_q <= {flashSync_q[0], execute_from_flash_i};
      end
   end

   assign lockSync = lockSync_q[1];

`ifdef RST_DEBOUNCE_EN
   localparam int unsigned DebCntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DebCntW-1:0] debCnt_q, debCnt_d;
   logic btnLevel_q, btnLevel_d;

   // Accept a new button level only after it has been stable long enough;
   // any return to the current level restarts the count.
   always_comb begin
      debCnt_d   = '0;
      btnLevel_d = btnLevel_q;
      if (btnSync_q[1] != btnLevel_q) begin
         if (debCnt_q == DebCntW'(DEBOUNCE_CYCLES - 1)) begin
            btnLevel_d = btnSync_q[1];
            debCnt_d   = '0;
         end else begin
            debCnt_d = debCnt_q + DebCntW'(1);
         end
      end
   end

   // Debounce counter and filtered button level registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         debCnt_q   <= '0;
         btnLevel_q <= 1'b0;
      end else begin
         debCnt_q   <= debCnt_d;
         btnLevel_q <= btnLevel_d;
      end
   end

   assign btnFilt = btnLevel_q;
`else
   assign btnFilt = btnSync_q[1];
`endif

   // Remember the previous filtered level so a press yields a single pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btnPrev_q <= 1'b0;
      end else begin
         btnPrev_q <= btnFilt;
      end
   end

   assign btnEvent = btnFilt & ~btnPrev_q;

   // Next-state logic: lock loss beats a button restart, which beats exit capture.
   always_comb begin
      state_d      = state_q;
      holdCnt_d    = holdCnt_q;
      bootLatch_d  = bootLatch_q;
      flashLatch_d = flashLatch_q;
      exitDone_d   = exitDone_q;
      exitValue_d  = exitValue_q;

      case (state_q)
         WAIT_LOCK: begin
            if (lockSync) begin
               state_d     = HOLD;
               holdCnt_d   = '0;
               exitDone_d  = 1'b0;
               exitValue_d = '0;
            end
         end
         HOLD, RUN, DONE: begin
            if (!lockSync) begin
               state_d = WAIT_LOCK;
            end else if (btnEvent) begin
               state_d     = HOLD;
               holdCnt_d   = '0;
               exitDone_d  = 1'b0;
               exitValue_d = '0;
            end else begin
               case (state_q)
                  HOLD: begin
                     if (holdCnt_q == HoldCntW'(RST_HOLD_CYCLES - 1)) begin
                        state_d      = RUN;
                        bootLatch_d  = bootSync_q[1];
                        flashLatch_d = flashSync_q[1];
                     end else begin
                        holdCnt_d = holdCnt_q + HoldCntW'(1);
                     end
                  end
                  RUN: begin
                     if (exit_valid_i) begin
                        state_d     = DONE;
                        exitDone_d  = 1'b1;
                        exitValue_d = exit_value_i;
                     end
                  end
                  default: begin
                     state_d = state_q;
                  end
               endcase
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      socRstN_d = (state_d == RUN) || (state_d == DONE);
   end

   // Sequencer state, latched straps, exit capture and the registered SoC reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= WAIT_LOCK;
         holdCnt_q    <= '0;
         bootLatch_q  <= 1'b0;
         flashLatch_q <= 1'b0;
         exitDone_q   <= 1'b0;
         exitValue_q  <= '0;
         socRstN_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         holdCnt_q    <= holdCnt_d;
         bootLatch_q  <= bootLatch_d;
         flashLatch_q <= flashLatch_d;
         exitDone_q   <= exitDone_d;
         exitValue_q  <= exitValue_d;
         socRstN_q    <= socRstN_d;
      end
   end

   // Free-running blink counter; only the global reset clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ledCnt_q <= '0;
      end else begin
         ledCnt_q <= ledCnt_q + LedOne;
      end
   end

   assign soc_rst_no           = socRstN_q;
   assign rst_led_o            = socRstN_q;
   assign boot_select_o        = bootLatch_q;
   assign execute_from_flash_o = flashLatch_q;
   assign exit_done_o          = exitDone_q;
   assign exit_value_o         = exitValue_q;
   assign state_o              = state_q;
   assign clk_led_o            = ledCnt_q[CLK_LED_COUNT_LENGTH-1];

   // A clean exit lights the LED solid, a failing exit makes it blink.
   always_comb begin
      exit_led_o = 1'b0;
      if (state_q == DONE) begin
         exit_led_o = (exitValue_q == 32'd0) ? 1'b1 : clk_led_o;
      end
   end

endmodule

// File: tb/tb_fpga_reset_boot_sequencer.sv
// tb_fpga_reset_boot_sequencer
// Directed bench for fpga_reset_boot_sequencer with RST_HOLD_CYCLES=4,
// DEBOUNCE_CYCLES=8 and a 4-bit LED counter. Honours RST_DEBOUNCE_EN.
module tb_fpga_reset_boot_sequencer;

   localparam int unsigned HoldCycles = 4;
   localparam int unsigned DebCycles  = 8;
   localparam int unsigned LedW       = 4;
`ifdef RST_DEBOUNCE_EN
   localparam int BtnLat = 2 + DebCycles;
`else
   localparam int BtnLat = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn = 1'b0;
   logic        lock = 1'b0;
   logic        boot = 1'b0;
   logic        flash = 1'b0;
   logic        exitValid = 1'b0;
   logic [31:0] exitValue = 32'd0;

   logic        socRstN;
   logic        bootSelO;
   logic        flashO;
   logic        exitDone;
   logic [31:0] exitValueO;
   logic [2:0]  stateO;
   logic        rstLed;
   logic        clkLed;
   logic        exitLed;

   logic [LedW-1:0] ledModel;

   int checks = 0;
   int errors = 0;

   fpga_reset_boot_sequencer #(
      .RST_HOLD_CYCLES      (HoldCycles),
      .DEBOUNCE_CYCLES      (DebCycles),
      .CLK_LED_COUNT_LENGTH (LedW)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .rst_btn_i            (btn),
      .pll_locked_i         (lock),
      .boot_select_i        (boot),
      .execute_from_flash_i (flash),
      .exit_valid_i         (exitValid),
      .exit_value_i         (exitValue),
      .soc_rst_no           (socRstN),
      .boot_select_o        (bootSelO),
      .execute_from_flash_o (flashO),
      .exit_done_o          (exitDone),
      .exit_value_o         (exitValueO),
      .state_o              (stateO),
      .rst_led_o            (rstLed),
      .clk_led_o            (clkLed),
      .exit_led_o           (exitLed)
   );

   // 100 MHz style clock.
   always #5 clk = ~clk;

   // Reference free-running counter: cleared by the global reset only.
   always @(posedge clk or posedge rst) begin
      if (rst) ledModel <= '0;
      else     ledModel <= ledModel + LedW'(1);
   end

   // Advance the given number of rising edges and settle just after the last.
   task automatic applyStimulus(input int edges);
      repeat (edges) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Press the button long enough to register and confirm the restart into HOLD.
   task automatic pressButton(input logic [2:0] priorState, input string tag);
      btn = 1'b1;
      applyStimulus(BtnLat);
      checkOutput({tag, "_pre_state"}, {29'd0, stateO}, {29'd0, priorState});
      btn = 1'b0;
      applyStimulus(1);
      checkOutput({tag, "_state"}, {29'd0, stateO}, 32'd2);
      checkOutput({tag, "_soc_rst"}, {31'd0, socRstN}, 32'd0);
      checkOutput({tag, "_exit_done"}, {31'd0, exitDone}, 32'd0);
      checkOutput({tag, "_exit_value"}, exitValueO, 32'd0);
   endtask

   initial begin
      $display("[TB] start, BtnLat=%0d", BtnLat);

      // Reset values while rst is held.
      rst = 1'b1;
      applyStimulus(2);
      checkOutput("rst_state", {29'd0, stateO}, 32'd1);
      checkOutput("rst_soc", {31'd0, socRstN}, 32'd0);
      checkOutput("rst_led", {31'd0, rstLed}, 32'd0);
      checkOutput("rst_boot", {31'd0, bootSelO}, 32'd0);
      checkOutput("rst_flash", {31'd0, flashO}, 32'd0);
      checkOutput("rst_exit_done", {31'd0, exitDone}, 32'd0);
      checkOutput("rst_exit_value", exitValueO, 32'd0);
      checkOutput("rst_clk_led", {31'd0, clkLed}, 32'd0);
      checkOutput("rst_exit_led", {31'd0, exitLed}, 32'd0);

      // Power-up without lock stays in WAIT_LOCK.
      rst = 1'b0;
      applyStimulus(12);
      checkOutput("nolock_state", {29'd0, stateO}, 32'd1);
      checkOutput("nolock_soc", {31'd0, socRstN}, 32'd0);
      checkOutput("clk_led_model_a", {31'd0, clkLed}, {31'd0, ledModel[LedW-1]});

      // Lock up with straps boot=1 / flash=0.
      boot  = 1'b1;
      flash = 1'b0;
      lock  = 1'b1;
      applyStimulus(2);
      checkOutput("lock_edge1_state", {29'd0, stateO}, 32'd1);
      applyStimulus(1);
      checkOutput("lock_hold_state", {29'd0, stateO}, 32'd2);
      checkOutput("lock_hold_soc", {31'd0, socRstN}, 32'd0);
      applyStimulus(3);
      checkOutput("hold3_soc", {31'd0, socRstN}, 32'd0);
      checkOutput("hold3_boot_unlatched", {31'd0, bootSelO}, 32'd0);
      applyStimulus(1);
      checkOutput("run_state", {29'd0, stateO}, 32'd3);
      checkOutput("run_soc", {31'd0, socRstN}, 32'd1);
      checkOutput("run_rst_led", {31'd0, rstLed}, 32'd1);
      checkOutput("run_boot", {31'd0, bootSelO}, 32'd1);
      checkOutput("run_flash", {31'd0, flashO}, 32'd0);

      // Straps toggled in RUN must not affect latched values.
      boot  = 1'b0;
      flash = 1'b1;
      applyStimulus(4);
      checkOutput("toggle_boot", {31'd0, bootSelO}, 32'd1);
      checkOutput("toggle_flash", {31'd0, flashO}, 32'd0);

`ifdef RST_DEBOUNCE_EN
      // Bouncing button shorter than the debounce window: no restart.
      btn = 1'b1; applyStimulus(3);
      btn = 1'b0; applyStimulus(3);
      btn = 1'b1; applyStimulus(3);
      btn = 1'b0; applyStimulus(14);
      checkOutput("bounce_state", {29'd0, stateO}, 32'd3);
      checkOutput("bounce_soc", {31'd0, socRstN}, 32'd1);
`endif

      // Exit with code 0: solid exit LED.
      exitValid = 1'b1;
      exitValue = 32'd0;
      applyStimulus(1);
      exitValid = 1'b0;
      checkOutput("exit0_state", {29'd0, stateO}, 32'd4);
      checkOutput("exit0_done", {31'd0, exitDone}, 32'd1);
      checkOutput("exit0_value", exitValueO, 32'd0);
      checkOutput("exit0_led", {31'd0, exitLed}, 32'd1);
      checkOutput("exit0_soc", {31'd0, socRstN}, 32'd1);

      // Button restart from DONE, then new straps latched at the next release.
      pressButton(3'd4, "btn1");
      applyStimulus(3);
      checkOutput("btn1_hold_boot_kept", {31'd0, bootSelO}, 32'd1);
      applyStimulus(1);
      checkOutput("btn1_run_state", {29'd0, stateO}, 32'd3);
      checkOutput("btn1_run_boot", {31'd0, bootSelO}, 32'd0);
      checkOutput("btn1_run_flash", {31'd0, flashO}, 32'd1);

      // Exit with code 5: exit LED blinks with the clock LED.
      exitValid = 1'b1;
      exitValue = 32'h0000_0005;
      applyStimulus(1);
      exitValid = 1'b0;
      checkOutput("exit5_done", {31'd0, exitDone}, 32'd1);
      checkOutput("exit5_value", exitValueO, 32'h5);
      checkOutput("exit5_led_a", {31'd0, exitLed}, {31'd0, ledModel[LedW-1]});
      applyStimulus(8);
      checkOutput("exit5_led_b", {31'd0, exitLed}, {31'd0, ledModel[LedW-1]});

      // Second exit pulse in DONE is ignored.
      exitValid = 1'b1;
      exitValue = 32'h0000_0007;
      applyStimulus(1);
      exitValid = 1'b0;
      checkOutput("exit7_ignored_value", exitValueO, 32'h5);
      checkOutput("exit7_state", {29'd0, stateO}, 32'd4);

      // Restart and run, then lock loss + button + exit_valid in the same cycle.
      pressButton(3'd4, "btn2");
      applyStimulus(4);
      checkOutput("btn2_run_state", {29'd0, stateO}, 32'd3);
      lock = 1'b0;
      btn  = 1'b1;
      applyStimulus(2);
      checkOutput("prio_pre_state", {29'd0, stateO}, 32'd3);
      exitValid = 1'b1;
      exitValue = 32'h0000_0009;
      applyStimulus(1);
      exitValid = 1'b0;
      btn       = 1'b0;
      checkOutput("prio_state", {29'd0, stateO}, 32'd1);
      checkOutput("prio_exit_done", {31'd0, exitDone}, 32'd0);
      checkOutput("prio_exit_value", exitValueO, 32'd0);
      checkOutput("prio_soc", {31'd0, socRstN}, 32'd0);
      applyStimulus(BtnLat + 4);
      checkOutput("wait_lock_btn_ignored", {29'd0, stateO}, 32'd1);

      // Relock, then assert rst_i at hold count 2.
      lock = 1'b1;
      applyStimulus(3);
      checkOutput("relock_state", {29'd0, stateO}, 32'd2);
      applyStimulus(2);
      rst = 1'b1;
      #1;
      checkOutput("midrst_state", {29'd0, stateO}, 32'd1);
      checkOutput("midrst_soc", {31'd0, socRstN}, 32'd0);
      checkOutput("midrst_boot", {31'd0, bootSelO}, 32'd0);
      checkOutput("midrst_flash", {31'd0, flashO}, 32'd0);
      checkOutput("midrst_clk_led", {31'd0, clkLed}, 32'd0);
      checkOutput("midrst_exit_led", {31'd0, exitLed}, 32'd0);
      applyStimulus(2);
      rst = 1'b0;
      applyStimulus(2);
      checkOutput("postrst_wait_state", {29'd0, stateO}, 32'd1);
      applyStimulus(1);
      checkOutput("postrst_hold_state", {29'd0, stateO}, 32'd2);
      applyStimulus(3);
      checkOutput("postrst_hold3_soc", {31'd0, socRstN}, 32'd0);
      applyStimulus(1);
      checkOutput("postrst_run_soc", {31'd0, socRstN}, 32'd1);
      checkOutput("postrst_run_state", {29'd0, stateO}, 32'd3);
      checkOutput("postrst_run_flash", {31'd0, flashO}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
